// File: rtl/sid_wr_sched.sv
// rtl/sid_wr_sched.sv - SID register-write scheduler: A/B arbitration, write FIFO, clear sequencer
module sid_wr_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter bit CLR_ON_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       a_req,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ack,
  input  logic       clear,
  output logic       sid_we,
  output logic [4:0] sid_addr,
  output logic [7:0] sid_data,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [4:0] CLR_LAST = 5'h18;

  logic [0:0]    state;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [4:0]    clr_cnt;
  logic          last_grant_b;
  logic [12:0]   fifo_mem [FIFO_DEPTH];

  logic        can_push;
  logic        grant_a;
  logic        grant_b;
  logic        push;
  logic        pop;
  logic [12:0] push_entry;
  logic [12:0] head;

  // A wins a tie unless it was the last one granted.
  always_comb begin
    can_push   = 1'b0;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    push_entry = 13'd0;
    head       = fifo_mem[rd_ptr];
    can_push   = !clear && (state == ST_IDLE) && (count < DEPTH_C);
    grant_a    = can_push && a_req && (!b_req || last_grant_b);
    grant_b    = can_push && b_req && !grant_a;
    push       = grant_a || grant_b;
    push_entry = grant_a ? {a_addr, a_data} : {b_addr, b_data};
    pop        = !clear && (state == ST_IDLE) && ce_1m && (count != '0);
  end

  assign a_ack = grant_a && reset_n;
  assign b_ack = grant_b && reset_n;
  assign busy  = (state == ST_CLEAR) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CLR_ON_INIT ? ST_CLEAR : ST_IDLE;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      clr_cnt      <= 5'd0;
      last_grant_b <= 1'b1;
      sid_we       <= 1'b0;
      sid_addr     <= 5'd0;
      sid_data     <= 8'd0;
    end else begin
      sid_we <= 1'b0;
      if (clear) begin
        state   <= ST_CLEAR;
        count   <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        clr_cnt <= 5'd0;
      end else if (state == ST_CLEAR) begin
        if (ce_1m) begin
          sid_we   <= 1'b1;
          sid_addr <= clr_cnt;
          sid_data <= 8'd0;
          if (clr_cnt == CLR_LAST) begin
            state   <= ST_IDLE;
            clr_cnt <= 5'd0;
          end else begin
            clr_cnt <= clr_cnt + 5'd1;
          end
        end
      end else begin
        if (push) begin
          wr_ptr       <= wr_ptr + 1'b1;
          last_grant_b <= grant_b;
        end
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          sid_we   <= 1'b1;
          sid_addr <= head[12:8];
          sid_data <= head[7:0];
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sid_wr_sched.sv
// tb/tb_sid_wr_sched.sv - directed self-checking bench for sid_wr_sched
module tb_sid_wr_sched;

  logic       clk;
  logic       reset_n;
  logic       ce_1m;
  logic       a_req;
  logic [4:0] a_addr;
  logic [7:0] a_data;
  logic       b_req;
  logic [4:0] b_addr;
  logic [7:0] b_data;
  logic       clear;

  logic       a_ack, b_ack, sid_we, busy;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       a_ack0, b_ack0, sid_we0, busy0;
  logic [4:0] sid_addr0;
  logic [7:0] sid_data0;

  int n_run;
  int n_fail;

  sid_wr_sched #(.FIFO_DEPTH(4), .CLR_ON_INIT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .clear(clear), .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .busy(busy)
  );

  sid_wr_sched #(.FIFO_DEPTH(4), .CLR_ON_INIT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack0),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack0),
    .clear(clear), .sid_we(sid_we0), .sid_addr(sid_addr0), .sid_data(sid_data0),
    .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  cnt;
    int  exp_addr;
    bit  acked_early;
    bit  pend;
    bit  restarted;

    n_run = 0;
    n_fail = 0;
    reset_n = 1'b0;
    ce_1m = 1'b0;
    a_req = 1'b1; a_addr = 5'h02; a_data = 8'h99;
    b_req = 1'b0; b_addr = 5'h00; b_data = 8'h00;
    clear = 1'b0;

    // reset state
    step();
    step();
    chk("rst_we", 32'(sid_we), 0);
    chk("rst_addr", 32'(sid_addr), 0);
    chk("rst_data", 32'(sid_data), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_ack0", 32'(a_ack0), 0);
    chk("rst_addr0", 32'(sid_addr0), 0);

    // reset clear sequence, ce_1m every 32 clk, A held requesting
    reset_n = 1'b1;
    cnt = 0;
    acked_early = 1'b0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      ce_1m = (cyc % 32 == 31);
      #1;
      if (a_ack) acked_early = 1'b1;
      step();
      if (sid_we) begin
        chk("clr_addr", 32'(sid_addr), cnt);
        chk("clr_data", 32'(sid_data), 0);
        cnt++;
      end
      if (!busy) break;
    end
    a_req = 1'b0;
    ce_1m = 1'b0;
    chk("clr_count", cnt, 25);
    chk("clr_busy_end", 32'(busy), 0);
    chk("clr_no_ack", 32'(acked_early), 0);

    // contention: A 0x00<-0x11, B 0x07<-0x22, no ce_1m
    a_req = 1'b1; a_addr = 5'h00; a_data = 8'h11;
    b_req = 1'b1; b_addr = 5'h07; b_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_a_ack", 32'(a_ack), (i % 2 == 0) ? 1 : 0);
      chk("cont_b_ack", 32'(b_ack), (i % 2 == 1) ? 1 : 0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_a_ack", 32'(a_ack), 0);
      chk("full_b_ack", 32'(b_ack), 0);
      step();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk("cont_busy", 32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      ce_1m = 1'b1;
      step();
      ce_1m = 1'b0;
      chk("cont_we", 32'(sid_we), 1);
      chk("cont_addr", 32'(sid_addr), (k % 2 == 0) ? 32'h00 : 32'h07);
      chk("cont_data", 32'(sid_data), (k % 2 == 0) ? 32'h11 : 32'h22);
      step();
      chk("cont_we_1clk", 32'(sid_we), 0);
    end
    chk("cont_busy_end", 32'(busy), 0);

    // single A write 0x04<-0x41
    a_req = 1'b1; a_addr = 5'h04; a_data = 8'h41;
    #1;
    chk("single_ack", 32'(a_ack), 1);
    step();
    a_req = 1'b0;
    chk("single_busy", 32'(busy), 1);
    step();
    step();
    chk("single_no_we", 32'(sid_we), 0);
    ce_1m = 1'b1;
    step();
    ce_1m = 1'b0;
    chk("single_we", 32'(sid_we), 1);
    chk("single_addr", 32'(sid_addr), 32'h04);
    chk("single_data", 32'(sid_data), 32'h41);
    step();
    chk("single_we_drop", 32'(sid_we), 0);
    chk("single_hold_addr", 32'(sid_addr), 32'h04);

    // push and pop on the same edge; second entry uses unfiltered address 0x19
    a_req = 1'b1; a_addr = 5'h01; a_data = 8'h55;
    step();
    a_addr = 5'h19; a_data = 8'h66;
    ce_1m = 1'b1;
    #1;
    chk("pp_ack", 32'(a_ack), 1);
    step();
    a_req = 1'b0;
    ce_1m = 1'b0;
    chk("pp_we", 32'(sid_we), 1);
    chk("pp_addr", 32'(sid_addr), 32'h01);
    chk("pp_data", 32'(sid_data), 32'h55);
    chk("pp_busy", 32'(busy), 1);
    step();
    step();
    ce_1m = 1'b1;
    step();
    ce_1m = 1'b0;
    chk("pp2_we", 32'(sid_we), 1);
    chk("pp2_addr", 32'(sid_addr), 32'h19);
    chk("pp2_data", 32'(sid_data), 32'h66);
    chk("pp2_busy", 32'(busy), 0);

    // clear mid-stream with 3 entries queued, second clear at clr_cnt 0x0A on a ce_1m edge
    a_req = 1'b1; a_addr = 5'h1A; a_data = 8'hA5;
    step();
    step();
    step();
    clear = 1'b1;
    #1;
    chk("clr_pulse_ack", 32'(a_ack), 0);
    step();
    clear = 1'b0;
    a_req = 1'b0;
    chk("clr_pulse_busy", 32'(busy), 1);
    exp_addr = 0;
    pend = 1'b0;
    restarted = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ce_1m = (cyc % 4 == 3);
      clear = pend && ce_1m;
      step();
      if (clear) begin
        chk("clr_on_ce_we", 32'(sid_we), 0);
        clear = 1'b0;
        pend = 1'b0;
        restarted = 1'b1;
        exp_addr = 0;
      end else if (sid_we) begin
        chk("mid_addr", 32'(sid_addr), exp_addr);
        chk("mid_data", 32'(sid_data), 0);
        exp_addr++;
        if (!restarted && exp_addr == 10) pend = 1'b1;
      end
      if (restarted && !busy) break;
    end
    ce_1m = 1'b0;
    clear = 1'b0;
    chk("mid_restarted", 32'(restarted), 1);
    chk("mid_count", exp_addr, 25);

    // reset mid-write
    a_req = 1'b1; a_addr = 5'h03; a_data = 8'h33;
    step();
    a_data = 8'h34;
    step();
    a_req = 1'b0;
    ce_1m = 1'b1;
    step();
    ce_1m = 1'b0;
    chk("rmw_we", 32'(sid_we), 1);
    chk("rmw_addr", 32'(sid_addr), 32'h03);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmw_we_async", 32'(sid_we), 0);
    chk("rmw_we0_async", 32'(sid_we0), 0);
    a_req = 1'b1; a_addr = 5'h05; a_data = 8'h77;
    #1;
    chk("rmw_ack_rst", 32'(a_ack), 0);
    chk("rmw_ack0_rst", 32'(a_ack0), 0);
    chk("rmw_busy", 32'(busy), 1);
    chk("rmw_busy0", 32'(busy0), 0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("rmw_ack0_first", 32'(a_ack0), 1);
    chk("rmw_ack_clear", 32'(a_ack), 0);
    step();
    a_req = 1'b0;
    chk("rmw_busy0_push", 32'(busy0), 1);
    ce_1m = 1'b1;
    step();
    ce_1m = 1'b0;
    chk("rmw_we0", 32'(sid_we0), 1);
    chk("rmw_addr0", 32'(sid_addr0), 32'h05);
    chk("rmw_data0", 32'(sid_data0), 32'h77);
    chk("rmw_busy0_end", 32'(busy0), 0);
    chk("rmw_clr_we", 32'(sid_we), 1);
    chk("rmw_clr_addr", 32'(sid_addr), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
